fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock.
REQ-002 SHALL expose: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL expose: pc_next  input  16  next PC from pc_control (PC+2, branch target or Rs).
REQ-004 SHALL expose: branch_taken  input  1  redirect/flush from ID-stage branch resolution.
REQ-005 SHALL expose: stall  input  1  ID hazard stall; hold IF/ID and PC.
REQ-006 SHALL expose: imem_req  output  1  instruction-memory read request.
REQ-007 SHALL expose: imem_addr  output  16  read address, equals pc_cur.
REQ-008 SHALL expose: imem_valid  input  1  one-cycle pulse, imem_rdata valid.
REQ-009 SHALL expose: imem_rdata  input  16  fetched instruction.
REQ-010 SHALL expose: pc_cur  output  16  current fetch PC, feeds pc_control pc_in.
REQ-011 SHALL expose: if_id_instr  output  16  / if_id_pc  output  16 (fetch PC+2)  / if_id_valid  output  1.
REQ-012 SHALL expose: halted  output  1  core stopped on HLT.

Function
REQ-013 SHALL implement states FETCH, HOLD, DISCARD, HALT.
REQ-014 FETCH: imem_req=1, imem_addr=pc_cur; on imem_valid with no stall/branch, load IF/ID {rdata, pc_cur+2, valid=1} and load pc_cur<=pc_next in the same edge.
REQ-015 Latency: one instruction per cycle when imem_valid returns combinationally; otherwise IF/ID valid=0 (bubble) each cycle without imem_valid.
REQ-016 stall=1 with imem_valid: capture rdata in one-entry skid register, go HOLD, imem_req=0; PC and IF/ID unchanged.
REQ-017 HOLD: on stall=0, move skid to IF/ID, update PC, return FETCH; no new request issued while in HOLD.
REQ-018 branch_taken SHALL have priority over stall and imem_valid: IF/ID valid<=0, instr<=NOP, skid cleared, pc_cur<=pc_next.
REQ-019 branch_taken while a request is outstanding (imem_req=1, no imem_valid yet) SHALL go DISCARD; the next imem_valid is dropped, then FETCH at the new PC.
REQ-020 rdata[15:12]==HLT opcode accepted into IF/ID: go HALT, imem_req=0, pc_cur frozen, halted=1 from next cycle.
REQ-021 HALT: branch_taken SHALL exit to FETCH at pc_next and clear halted (wrong-path HLT); otherwise remain until reset.
REQ-022 PC arithmetic 16-bit modulo; 0xFFFE+2 wraps to 0x0000 in if_id_pc.

Reset
REQ-023 rst_n low SHALL asynchronously force: pc_cur=0x0000, state FETCH, if_id_valid=0, if_id_instr=NOP, if_id_pc=0x0000, halted=0, skid empty; imem_req=1 one cycle after release.
REQ-024 Reset mid-request SHALL abandon the transaction; a late imem_valid after release in FETCH is treated as the PC 0x0000 response.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN defined: add outputs perf_stall_cnt[15:0] (HOLD or stalled cycles) and perf_flush_cnt[15:0] (branch_taken cycles), saturating at 0xFFFF, reset to 0.
REQ-026 Macro undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold NOP encoding, HLT opcode, reset PC, state enum.
REQ-028 PC+2 SHALL reuse adder_sub_16bit; no other sub-module.

Verification
REQ-029 Reset, imem_valid each cycle with 0x1234, 0x2345 -> IF/ID pc 0x0002, 0x0004; pc_cur 0x0002, 0x0004.
REQ-030 stall=1 on the cycle imem_valid returns 0xABCD -> HOLD, imem_req=0; stall release -> if_id_instr=0xABCD next edge.
REQ-031 branch_taken, pc_next=0x0040 with a request outstanding -> late imem_valid dropped; next fetch addr 0x0040, if_id_valid=0 for the flush cycle.
REQ-032 Fetch 0xF000 (HLT) -> halted=1, imem_req=0, pc_cur frozen; then branch_taken, pc_next=0x0100 -> halted=0, fetch at 0x0100.
REQ-033 pc_cur=0xFFFE fetch -> if_id_pc=0x0000; rst_n pulsed mid-HOLD -> all outputs at REQ-023 values immediately.
REQ-034 FETCH_PERF_CNT_EN defined, 3 stall cycles and 2 flushes -> perf_stall_cnt=3, perf_flush_cnt=2.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: encodings, reset PC,
// fetch state enum and the HLT decode helper.
package fetch_unit_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] PC_STEP    = 16'h0002;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:12] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_adder_sub_16bit.sv
// 16-bit modulo adder/subtractor shared with the rest of the core; the fetch
// unit uses it only to form PC+2.
module adder_sub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] result
);

  assign result = sub ? (a - b) : (a + b);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer, flush handling and HLT stop.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        branch_taken,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_cur,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic         req_armed_q;
  logic [15:0]  pc_q;
  logic [15:0]  pc_plus2;
  logic [15:0]  skid_q;
  logic         req_active;
  logic         redirect;
  logic         load_fetch;
  logic         load_skid;
  logic         capture_skid;

  adder_sub_16bit u_pc_add (
    .a      (pc_q),
    .b      (PC_STEP),
    .sub    (1'b0),
    .result (pc_plus2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // A request is held open in FETCH from the first cycle after reset release.
  assign req_active = (state_q == FETCH) && req_armed_q;

  always_comb begin
    state_d      = state_q;
    redirect     = 1'b0;
    load_fetch   = 1'b0;
    load_skid    = 1'b0;
    capture_skid = 1'b0;
    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          redirect = 1'b1;
          state_d  = (req_active && !imem_valid) ? DISCARD : FETCH;
        end else if (imem_valid && stall) begin
          capture_skid = 1'b1;
          state_d      = HOLD;
        end else if (imem_valid) begin
          load_fetch = 1'b1;
          state_d    = is_halt(imem_rdata) ? HALT : FETCH;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          redirect = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          load_skid = 1'b1;
          state_d   = is_halt(skid_q) ? HALT : FETCH;
        end
      end
      DISCARD: begin
        if (branch_taken) redirect = 1'b1;
        if (imem_valid) state_d = FETCH;
      end
      HALT: begin
        if (branch_taken) begin
          redirect = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = req_active;
    imem_addr = pc_q;
    pc_cur    = pc_q;
    halted    = (state_q == HALT);
  end

  // Without an accepted instruction the IF/ID register bubbles unless ID is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_armed_q <= 1'b0;
      pc_q        <= RESET_PC;
      skid_q      <= NOP_INSTR;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
    end else begin
      req_armed_q <= 1'b1;
      if (redirect) begin
        pc_q        <= pc_next;
        skid_q      <= NOP_INSTR;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (load_fetch || load_skid) begin
        pc_q        <= pc_next;
        if_id_instr <= load_skid ? skid_q : imem_rdata;
        if_id_pc    <= pc_plus2;
        if_id_valid <= 1'b1;
        if (load_skid) skid_q <= NOP_INSTR;
      end else if (capture_skid) begin
        skid_q <= imem_rdata;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 16'h0000;
      perf_flush_cnt <= 16'h0000;
    end else begin
      if ((state_q == HOLD || stall) && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (branch_taken && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model with a variable-latency instruction memory.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_next = 16'h0000;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] pc_cur;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model of the fetch stage
  logic [15:0] m_pc, m_instr, m_ifpc, m_skid;
  bit          m_valid, m_holding, m_discarding, m_halted, m_armed;
  logic [15:0] m_stall_cnt, m_flush_cnt;

  // Instruction memory model
  bit mem_busy;
  int mem_lat;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_next      (pc_next),
    .branch_taken (branch_taken),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .pc_cur       (pc_cur),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, actual, expected);
    end
  endtask

  function automatic bit model_req();
    return m_armed && !m_holding && !m_discarding && !m_halted;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_ifpc = 16'h0000; m_skid = NOP;
    m_valid = 0; m_holding = 0; m_discarding = 0; m_halted = 0; m_armed = 0;
    m_stall_cnt = 16'h0000; m_flush_cnt = 16'h0000;
    mem_busy = 0; mem_lat = 0;
  endtask

  task automatic model_accept(input logic [15:0] word);
    m_instr = word;
    m_ifpc  = m_pc + 16'd2;
    m_valid = 1;
    m_pc    = pc_next;
    if (word[15:12] == 4'hF) m_halted = 1;
  endtask

  // One clock of the fetch rules, evaluated with the inputs currently driven
  task automatic model_step();
    bit req;
    req = model_req();
    if ((m_holding || stall) && m_stall_cnt != 16'hFFFF) m_stall_cnt++;
    if (branch_taken && m_flush_cnt != 16'hFFFF) m_flush_cnt++;
    if (branch_taken) begin
      if (m_discarding) m_discarding = !imem_valid;
      else              m_discarding = req && !imem_valid;
      m_halted = 0; m_holding = 0; m_skid = NOP;
      m_pc = pc_next; m_valid = 0; m_instr = NOP;
    end else if (m_halted) begin
      if (!stall) m_valid = 0;
    end else if (m_discarding) begin
      if (imem_valid) m_discarding = 0;
      if (!stall) m_valid = 0;
    end else if (m_holding) begin
      if (!stall) begin
        m_holding = 0;
        model_accept(m_skid);
        m_skid = NOP;
      end
    end else if (imem_valid) begin
      if (stall) begin
        m_skid = imem_rdata;
        m_holding = 1;
      end else begin
        model_accept(imem_rdata);
      end
    end else if (!stall) begin
      m_valid = 0;
    end
    m_armed = 1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc_cur"}, pc_cur, m_pc);
    checkOutput({tag, ".imem_addr"}, imem_addr, m_pc);
    checkOutput({tag, ".imem_req"}, {15'd0, imem_req}, {15'd0, model_req()});
    checkOutput({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, m_valid});
    checkOutput({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halted});
    if (m_valid) begin
      checkOutput({tag, ".instr"}, if_id_instr, m_instr);
      checkOutput({tag, ".if_pc"}, if_id_pc, m_ifpc);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, ".perf_stall"}, perf_stall_cnt, m_stall_cnt);
    checkOutput({tag, ".perf_flush"}, perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic applyStimulus(input bit st, input bit br, input logic [15:0] pn,
                               input bit v, input logic [15:0] d, input string tag);
    stall = st; branch_taken = br; pc_next = pn; imem_valid = v; imem_rdata = d;
    model_step();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".pc_cur"}, pc_cur, 16'h0000);
    checkOutput({tag, ".valid"}, {15'd0, if_id_valid}, 16'h0000);
    checkOutput({tag, ".instr"}, if_id_instr, NOP);
    checkOutput({tag, ".if_pc"}, if_id_pc, 16'h0000);
    checkOutput({tag, ".halted"}, {15'd0, halted}, 16'h0000);
    checkOutput({tag, ".imem_req"}, {15'd0, imem_req}, 16'h0000);
  endtask

  initial begin
    bit v, st, br;
    logic [15:0] pn;
    model_reset();
    $display("[TB] fetch_unit bench starting");
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Back-to-back fetch, first response arrives right after reset release
    applyStimulus(0, 0, 16'h0002, 1, 16'h1234, "f1");
    checkOutput("f1.if_pc_const", if_id_pc, 16'h0002);
    checkOutput("f1.pc_const", pc_cur, 16'h0002);
    checkOutput("f1.instr_const", if_id_instr, 16'h1234);
    applyStimulus(0, 0, 16'h0004, 1, 16'h2345, "f2");
    checkOutput("f2.if_pc_const", if_id_pc, 16'h0004);
    checkOutput("f2.pc_const", pc_cur, 16'h0004);

    // Stall on the response cycle: skid holds it, no new request
    applyStimulus(1, 0, 16'h0006, 1, 16'hABCD, "hold1");
    checkOutput("hold1.req_const", {15'd0, imem_req}, 16'h0000);
    checkOutput("hold1.instr_const", if_id_instr, 16'h2345);
    applyStimulus(1, 0, 16'h0006, 0, 16'h0000, "hold2");
    applyStimulus(0, 0, 16'h0006, 0, 16'h0000, "hold_rel");
    checkOutput("hold_rel.instr_const", if_id_instr, 16'hABCD);
    checkOutput("hold_rel.if_pc_const", if_id_pc, 16'h0006);

    // Branch with a request outstanding: late response dropped
    applyStimulus(0, 1, 16'h0040, 0, 16'h0000, "flush");
    checkOutput("flush.valid_const", {15'd0, if_id_valid}, 16'h0000);
    applyStimulus(0, 0, 16'h0042, 1, 16'h5555, "drop");
    checkOutput("drop.valid_const", {15'd0, if_id_valid}, 16'h0000);
    checkOutput("drop.addr_const", imem_addr, 16'h0040);
    checkOutput("drop.req_const", {15'd0, imem_req}, 16'h0001);
    applyStimulus(0, 0, 16'h0042, 1, 16'h1111, "refetch");
    checkOutput("refetch.instr_const", if_id_instr, 16'h1111);

    // HLT stops fetch until a redirect
    applyStimulus(0, 0, 16'h0044, 1, 16'hF000, "hlt");
    checkOutput("hlt.halted_const", {15'd0, halted}, 16'h0001);
    checkOutput("hlt.req_const", {15'd0, imem_req}, 16'h0000);
    applyStimulus(0, 0, 16'h0046, 0, 16'h0000, "hlt_idle1");
    applyStimulus(0, 0, 16'h0048, 0, 16'h0000, "hlt_idle2");
    checkOutput("hlt_idle2.pc_const", pc_cur, 16'h0044);
    applyStimulus(0, 1, 16'h0100, 0, 16'h0000, "hlt_exit");
    checkOutput("hlt_exit.halted_const", {15'd0, halted}, 16'h0000);
    checkOutput("hlt_exit.addr_const", imem_addr, 16'h0100);
    checkOutput("hlt_exit.req_const", {15'd0, imem_req}, 16'h0001);

    // PC wrap, then asynchronous reset in the middle of HOLD
    applyStimulus(0, 1, 16'hFFFE, 1, 16'h9999, "to_fffe");
    applyStimulus(0, 0, 16'h0000, 1, 16'h0777, "wrap");
    checkOutput("wrap.if_pc_const", if_id_pc, 16'h0000);
    applyStimulus(1, 0, 16'h0002, 1, 16'h0888, "pre_rst_hold");
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_rst");
    model_reset();
    @(negedge clk);
    checkAll("in_rst");
    rst_n = 1'b1;

    // Three stalled cycles and two flushes from a clean reset
    applyStimulus(1, 0, 16'h0002, 0, 16'h0000, "st1");
    applyStimulus(1, 0, 16'h0002, 0, 16'h0000, "st2");
    applyStimulus(1, 0, 16'h0002, 0, 16'h0000, "st3");
    applyStimulus(0, 1, 16'h0010, 1, 16'h0001, "fl1");
    applyStimulus(0, 1, 16'h0020, 1, 16'h0002, "fl2");
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf.stall_const", perf_stall_cnt, 16'd3);
    checkOutput("perf.flush_const", perf_flush_cnt, 16'd2);
`endif

    // Randomized traffic against a variable-latency memory
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checkAll("rnd_rst");
        rst_n = 1'b1;
      end else begin
        if (!mem_busy && imem_req) begin
          mem_busy = 1;
          mem_lat  = $urandom_range(0, 2);
        end
        v = 0;
        if (mem_busy) begin
          if (mem_lat == 0) begin
            v = 1;
            mem_busy = 0;
          end else begin
            mem_lat--;
          end
        end
        st = ($urandom_range(0, 3) == 0);
        br = ($urandom_range(0, 7) == 0);
        pn = br ? (16'($urandom) & 16'hFFFE) : (m_pc + 16'd2);
        applyStimulus(st, br, pn, v, 16'($urandom), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
